// File: rtl/lpddr2_seq_pkg.sv
// Shared types and defaults for the LPDDR2 fetch/execute phase sequencer.
// The core presents 30-bit word addresses; the controller sees a narrower word address.
package lpddr2_seq_pkg;

    localparam int DEF_ADDR_W  = 27;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 1023;
    localparam int CORE_WORD_W = 30;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH_REQ = 3'd1,
        S_EXEC      = 3'd2,
        S_DATA_RD   = 3'd3,
        S_DATA_WR   = 3'd4,
        S_COMMIT    = 3'd5,
        S_DRAIN     = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    // Clears every bit at or above addr_w so the low slice is the controller address.
    function automatic logic [CORE_WORD_W-1:0] trunc_word(
        input logic [CORE_WORD_W-1:0] word,
        input int                     addr_w
    );
        logic [CORE_WORD_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < CORE_WORD_W; i++) begin
            if (i < addr_w) begin
                mask[i] = 1'b1;
            end
        end
        return word & mask;
    endfunction

endpackage

// File: rtl/lpddr2_req_watchdog.sv
// Counts cycles a memory request stays outstanding and flags the cycle in which
// the count would reach TIMEOUT, so the sequencer can abandon the request.
module lpddr2_req_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    // Saturates at TIMEOUT so a stuck enable can never wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != MAX_CNT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = i_en && (r_count >= LAST_CNT);

endmodule

// File: rtl/lpddr2_phase_sequencer.sv
// Alternates the single LPDDR2 port between instruction fetch and the execute-phase
// data access, and emits the one-cycle commit strobe when an instruction retires.
module lpddr2_phase_sequencer
    import lpddr2_seq_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_ena,
    input  logic                   i_jisr,
    input  logic [CORE_WORD_W-1:0] i_pc_word,
    input  logic [CORE_WORD_W-1:0] i_data_word,
    input  logic [DATA_W-1:0]      i_store_data,
    input  logic                   i_mem_rren,
    input  logic                   i_mem_wren,
    output logic [DATA_W-1:0]      o_instr,
    output logic [DATA_W-1:0]      o_load_data,
    output logic                   o_e,
    output logic                   o_fetch_phase,
    output logic                   o_abort,
    output logic [ADDR_W-1:0]      o_lpddr2_address,
    output logic [DATA_W-1:0]      o_lpddr2_write_data,
    input  logic [DATA_W-1:0]      i_lpddr2_read_data,
    output logic                   o_lpddr2_rreq,
    output logic                   o_lpddr2_wreq,
    input  logic                   i_lpddr2_ack
);

    state_t r_state;
    state_t w_next_state;

    logic r_rreq;
    logic r_wreq;
    logic r_e;
    logic r_fetch;
    logic r_abort;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_load;

    logic w_busy;
    logic w_ack;
    logic w_expired;
    logic w_rreq_nxt;
    logic w_wreq_nxt;
    logic w_e_nxt;
    logic w_fetch_nxt;
    logic w_abort_nxt;
    logic w_req_start;
    logic [CORE_WORD_W-1:0] w_pc_masked;
    logic [CORE_WORD_W-1:0] w_data_masked;
    logic w_unused_hi;

    // An ack only means something while one of our requests is actually raised.
    assign w_busy = r_rreq | r_wreq;
    assign w_ack  = i_lpddr2_ack & w_busy;

    assign w_pc_masked   = trunc_word(i_pc_word, ADDR_W);
    assign w_data_masked = trunc_word(i_data_word, ADDR_W);
    assign w_unused_hi   = ^{w_pc_masked[CORE_WORD_W-1:ADDR_W],
                             w_data_masked[CORE_WORD_W-1:ADDR_W]};

    lpddr2_req_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (i_lpddr2_ack | ~w_busy),
        .i_en      (w_busy),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ack beats the watchdog in the same cycle; jisr beats everything except expiry/HALT.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_ena) begin
                    w_next_state = S_FETCH_REQ;
                end
            end
            S_FETCH_REQ: begin
                if (w_ack) begin
                    w_next_state = i_jisr ? S_FETCH_REQ : S_EXEC;
                end else if (w_expired) begin
                    w_next_state = S_HALT;
                end else if (i_jisr && w_busy) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_EXEC: begin
                if (i_jisr) begin
                    w_next_state = S_FETCH_REQ;
                end else if (i_mem_wren) begin
                    w_next_state = S_DATA_WR;
                end else if (i_mem_rren) begin
                    w_next_state = S_DATA_RD;
                end else begin
                    w_next_state = S_COMMIT;
                end
            end
            S_DATA_RD, S_DATA_WR: begin
                if (w_ack) begin
                    w_next_state = i_jisr ? S_FETCH_REQ : S_COMMIT;
                end else if (w_expired) begin
                    w_next_state = S_HALT;
                end else if (i_jisr) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_COMMIT: begin
                if (i_jisr || i_ena) begin
                    w_next_state = S_FETCH_REQ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_ack) begin
                    w_next_state = S_FETCH_REQ;
                end else if (w_expired) begin
                    w_next_state = S_HALT;
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Requests always drop for at least one cycle after an ack, even when the
    // following state issues a new request straight away.
    always_comb begin
        w_rreq_nxt = 1'b0;
        w_wreq_nxt = 1'b0;
        if (!w_ack) begin
            case (w_next_state)
                S_FETCH_REQ, S_DATA_RD: w_rreq_nxt = 1'b1;
                S_DATA_WR:              w_wreq_nxt = 1'b1;
                S_DRAIN: begin
                    w_rreq_nxt = r_rreq;
                    w_wreq_nxt = r_wreq;
                end
                default: begin
                    w_rreq_nxt = 1'b0;
                    w_wreq_nxt = 1'b0;
                end
            endcase
        end
        w_e_nxt     = (w_next_state == S_COMMIT);
        w_fetch_nxt = (w_next_state == S_FETCH_REQ);
        w_abort_nxt = r_abort | (w_next_state == S_HALT);
        w_req_start = (w_rreq_nxt | w_wreq_nxt) & ~w_busy;
    end

    // Address and write data are captured only on a rising request so they stay put until ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rreq  <= 1'b0;
            r_wreq  <= 1'b0;
            r_e     <= 1'b0;
            r_fetch <= 1'b0;
            r_abort <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_instr <= '0;
            r_load  <= '0;
        end else begin
            r_rreq  <= w_rreq_nxt;
            r_wreq  <= w_wreq_nxt;
            r_e     <= w_e_nxt;
            r_fetch <= w_fetch_nxt;
            r_abort <= w_abort_nxt;
            if (w_req_start) begin
                r_addr <= (w_next_state == S_FETCH_REQ) ? w_pc_masked[ADDR_W-1:0]
                                                        : w_data_masked[ADDR_W-1:0];
            end
            if (w_req_start && w_wreq_nxt) begin
                r_wdata <= i_store_data;
            end
            if ((r_state == S_FETCH_REQ) && (w_next_state == S_EXEC)) begin
                r_instr <= i_lpddr2_read_data;
            end
            if ((r_state == S_DATA_RD) && (w_next_state == S_COMMIT)) begin
                r_load <= i_lpddr2_read_data;
            end
        end
    end

    // A jisr arriving in COMMIT must still cancel the retirement already on the wire.
    assign o_e                 = r_e & ~i_jisr;
    assign o_instr             = r_instr;
    assign o_load_data         = r_load;
    assign o_fetch_phase       = r_fetch;
    assign o_abort             = r_abort;
    assign o_lpddr2_address    = r_addr;
    assign o_lpddr2_write_data = r_wdata;
    assign o_lpddr2_rreq       = r_rreq;
    assign o_lpddr2_wreq       = r_wreq;

endmodule

// File: tb/tb_lpddr2_phase_sequencer.sv
// Directed bench for lpddr2_phase_sequencer: a cycle table for fetch/load/store,
// then hand sequences for jisr drain, commit cancel, ena drop, watchdog and reset.
module tb_lpddr2_phase_sequencer;

    localparam int ADDR_W  = 27;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk;
    logic              rstN;
    logic              ena;
    logic              jisr;
    logic [29:0]       pcWord;
    logic [29:0]       dataWord;
    logic [DATA_W-1:0] storeData;
    logic              memRren;
    logic              memWren;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] loadData;
    logic              e;
    logic              fetchPhase;
    logic              abortOut;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;
    logic              memRreq;
    logic              memWreq;
    logic              memAck;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        string       name;
        logic        ena, jisr, ack, rren, wren;
        logic [29:0] pc, dw;
        logic [31:0] sd, rd;
        logic        expRreq, expWreq, expE, expFetch;
        logic [26:0] expAddr;
        logic [31:0] expWdata, expInstr, expLoad;
    } vec_t;

    vec_t vecs[$];

    lpddr2_phase_sequencer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                 (clk),
        .rst_n               (rstN),
        .i_ena               (ena),
        .i_jisr              (jisr),
        .i_pc_word           (pcWord),
        .i_data_word         (dataWord),
        .i_store_data        (storeData),
        .i_mem_rren          (memRren),
        .i_mem_wren          (memWren),
        .o_instr             (instr),
        .o_load_data         (loadData),
        .o_e                 (e),
        .o_fetch_phase       (fetchPhase),
        .o_abort             (abortOut),
        .o_lpddr2_address    (memAddr),
        .o_lpddr2_write_data (memWdata),
        .i_lpddr2_read_data  (memRdata),
        .o_lpddr2_rreq       (memRreq),
        .o_lpddr2_wreq       (memWreq),
        .i_lpddr2_ack        (memAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: bumps the total and, when it matches, the pass count.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    // Inputs change #1 after the rising edge; outputs are then read #1 after the next one.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void addVec(
        input string name, input logic en, input logic ji, input logic ak,
        input logic rr, input logic wr, input logic [29:0] pc, input logic [29:0] dw,
        input logic [31:0] sd, input logic [31:0] rd,
        input logic eR, input logic eW, input logic eE, input logic eF,
        input logic [26:0] eA, input logic [31:0] eWd, input logic [31:0] eI, input logic [31:0] eL
    );
        vec_t v;
        v.name = name; v.ena = en; v.jisr = ji; v.ack = ak; v.rren = rr; v.wren = wr;
        v.pc = pc; v.dw = dw; v.sd = sd; v.rd = rd;
        v.expRreq = eR; v.expWreq = eW; v.expE = eE; v.expFetch = eF;
        v.expAddr = eA; v.expWdata = eWd; v.expInstr = eI; v.expLoad = eL;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        ena = v.ena; jisr = v.jisr; memAck = v.ack; memRren = v.rren; memWren = v.wren;
        pcWord = v.pc; dataWord = v.dw; storeData = v.sd; memRdata = v.rd;
        step();
    endtask

    task automatic checkOutput(input vec_t v);
        checkVal({v.name, ".rreq"},  32'(memRreq),    32'(v.expRreq));
        checkVal({v.name, ".wreq"},  32'(memWreq),    32'(v.expWreq));
        checkVal({v.name, ".e"},     32'(e),          32'(v.expE));
        checkVal({v.name, ".fetch"}, 32'(fetchPhase), 32'(v.expFetch));
        checkVal({v.name, ".instr"}, instr,           v.expInstr);
        checkVal({v.name, ".load"},  loadData,        v.expLoad);
        checkVal({v.name, ".abort"}, 32'(abortOut),   32'd0);
        if (v.expRreq || v.expWreq) begin
            checkVal({v.name, ".addr"}, 32'(memAddr), 32'(v.expAddr));
        end
        if (v.expWreq) begin
            checkVal({v.name, ".wdata"}, memWdata, v.expWdata);
        end
    endtask

    initial begin
        rstN = 1'b0; ena = 1'b0; jisr = 1'b0; memAck = 1'b0; memRren = 1'b0; memWren = 1'b0;
        pcWord = '0; dataWord = '0; storeData = '0; memRdata = '0;

        repeat (3) @(posedge clk);
        #1;
        checkVal("reset.instr", instr, 32'd0);
        checkVal("reset.load", loadData, 32'd0);
        checkVal("reset.e", 32'(e), 32'd0);
        checkVal("reset.rreq", 32'(memRreq), 32'd0);
        checkVal("reset.wreq", 32'(memWreq), 32'd0);
        checkVal("reset.abort", 32'(abortOut), 32'd0);
        checkVal("reset.fetch", 32'(fetchPhase), 32'd0);
        rstN = 1'b1;

        //      name                  en ji ak rr wr pc     dw            sd            rd             R  W  E  F  addr        wdata         instr         load
        addVec("fetch0_issue",        1, 0, 0, 0, 0, 'h10, 'h0,         'h0,          'h0,           1, 0, 0, 1, 'h10,       'h0,          'h0,          'h0);
        addVec("fetch0_wait1",        1, 0, 0, 0, 0, 'h10, 'h0,         'h0,          'h0,           1, 0, 0, 1, 'h10,       'h0,          'h0,          'h0);
        addVec("fetch0_wait2",        1, 0, 0, 0, 0, 'h10, 'h0,         'h0,          'h0,           1, 0, 0, 1, 'h10,       'h0,          'h0,          'h0);
        addVec("fetch0_ack",          1, 0, 1, 0, 0, 'h10, 'h0,         'h0,          'h20010005,    0, 0, 0, 0, 'h0,        'h0,          'h20010005,   'h0);
        addVec("exec0_nomem",         1, 0, 0, 0, 0, 'h11, 'h0,         'h0,          'h0,           0, 0, 1, 0, 'h0,        'h0,          'h20010005,   'h0);
        addVec("fetch1_issue",        1, 0, 0, 0, 0, 'h11, 'h0,         'h0,          'h0,           1, 0, 0, 1, 'h11,       'h0,          'h20010005,   'h0);
        addVec("fetch1_ack",          1, 0, 1, 0, 0, 'h11, 'h0,         'h0,          'h8C000000,    0, 0, 0, 0, 'h0,        'h0,          'h8C000000,   'h0);
        addVec("load_issue",          1, 0, 0, 1, 0, 'h11, 'h38000123,  'h0,          'h0,           1, 0, 0, 0, 'h0000123,  'h0,          'h8C000000,   'h0);
        addVec("load_wait",           1, 0, 0, 0, 0, 'h11, 'h1,         'h0,          'h0,           1, 0, 0, 0, 'h0000123,  'h0,          'h8C000000,   'h0);
        addVec("load_ack",            1, 0, 1, 0, 0, 'h12, 'h1,         'h0,          'hCAFEF00D,    0, 0, 1, 0, 'h0,        'h0,          'h8C000000,   'hCAFEF00D);
        addVec("fetch2_issue",        1, 0, 0, 0, 0, 'h12, 'h0,         'h0,          'h0,           1, 0, 0, 1, 'h12,       'h0,          'h8C000000,   'hCAFEF00D);
        addVec("fetch2_ack",          1, 0, 1, 0, 0, 'h12, 'h0,         'h0,          'hAC000000,    0, 0, 0, 0, 'h0,        'h0,          'hAC000000,   'hCAFEF00D);
        addVec("store_issue",         1, 0, 0, 1, 1, 'h12, 'h04000456,  'hDEADBEEF,   'h0,           0, 1, 0, 0, 'h4000456,  'hDEADBEEF,   'hAC000000,   'hCAFEF00D);
        addVec("store_wait",          0, 0, 0, 0, 0, 'h12, 'h0,         'h11111111,   'h0,           0, 1, 0, 0, 'h4000456,  'hDEADBEEF,   'hAC000000,   'hCAFEF00D);
        addVec("store_ack",           0, 0, 1, 0, 0, 'h12, 'h0,         'h11111111,   'h12345678,    0, 0, 1, 0, 'h0,        'h0,          'hAC000000,   'hCAFEF00D);
        addVec("idle_after_commit",   0, 0, 0, 0, 0, 'h12, 'h0,         'h0,          'h0,           0, 0, 0, 0, 'h0,        'h0,          'hAC000000,   'hCAFEF00D);
        addVec("idle_ack_ignored",    0, 0, 1, 0, 0, 'h12, 'h0,         'h0,          'hFFFFFFFF,    0, 0, 0, 0, 'h0,        'h0,          'hAC000000,   'hCAFEF00D);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // jisr while a load is outstanding: drain, discard, refetch from the new pc
        memAck = 1'b0; ena = 1'b1; pcWord = 30'h20;
        step();
        checkVal("jisr.fetch_addr", 32'(memAddr), 32'h20);
        memAck = 1'b1; memRdata = 32'h8C000001;
        step();
        memAck = 1'b0; memRren = 1'b1; dataWord = 30'h55;
        step();
        checkVal("jisr.rd_rreq", 32'(memRreq), 32'd1);
        checkVal("jisr.rd_addr", 32'(memAddr), 32'h55);
        memRren = 1'b0; jisr = 1'b1; pcWord = 30'h30;
        step();
        jisr = 1'b0;
        checkVal("jisr.drain_rreq", 32'(memRreq), 32'd1);
        checkVal("jisr.drain_addr", 32'(memAddr), 32'h55);
        checkVal("jisr.drain_e", 32'(e), 32'd0);
        step();
        checkVal("jisr.drain2_rreq", 32'(memRreq), 32'd1);
        memAck = 1'b1; memRdata = 32'h99999999;
        step();
        memAck = 1'b0;
        checkVal("jisr.gap_rreq", 32'(memRreq), 32'd0);
        checkVal("jisr.load_kept", loadData, 32'hCAFEF00D);
        checkVal("jisr.gap_e", 32'(e), 32'd0);
        checkVal("jisr.gap_fetch", 32'(fetchPhase), 32'd1);
        step();
        checkVal("jisr.refetch_rreq", 32'(memRreq), 32'd1);
        checkVal("jisr.refetch_addr", 32'(memAddr), 32'h30);
        checkVal("jisr.refetch_e", 32'(e), 32'd0);
        memAck = 1'b1; memRdata = 32'h00000013;
        step();
        memAck = 1'b0;
        checkVal("jisr.refetch_instr", instr, 32'h00000013);
        step();
        checkVal("commit.e_before", 32'(e), 32'd1);

        // jisr in COMMIT cancels the strobe and forces a fetch despite ena low
        jisr = 1'b1; ena = 1'b0;
        #1;
        checkVal("commit.e_cancel", 32'(e), 32'd0);
        step();
        jisr = 1'b0;
        checkVal("commit.jisr_rreq", 32'(memRreq), 32'd1);
        checkVal("commit.jisr_fetch", 32'(fetchPhase), 32'd1);

        // ena already low during FETCH_REQ: instruction completes, then IDLE
        step();
        checkVal("enadrop.rreq_held", 32'(memRreq), 32'd1);
        memAck = 1'b1; memRdata = 32'h00000033;
        step();
        memAck = 1'b0;
        step();
        checkVal("enadrop.e", 32'(e), 32'd1);
        step();
        checkVal("enadrop.idle_rreq", 32'(memRreq), 32'd0);
        checkVal("enadrop.idle_e", 32'(e), 32'd0);
        step();
        checkVal("enadrop.idle2_rreq", 32'(memRreq), 32'd0);
        ena = 1'b1; pcWord = 30'h40;
        step();
        checkVal("enadrop.resume_rreq", 32'(memRreq), 32'd1);
        checkVal("enadrop.resume_addr", 32'(memAddr), 32'h40);

        // ack in the last permitted cycle (count TIMEOUT-1) is still accepted
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            step();
        end
        checkVal("wd.late_rreq", 32'(memRreq), 32'd1);
        checkVal("wd.late_abort", 32'(abortOut), 32'd0);
        memAck = 1'b1; memRdata = 32'h00000044;
        step();
        memAck = 1'b0;
        checkVal("wd.late_ack_abort", 32'(abortOut), 32'd0);
        checkVal("wd.late_ack_instr", instr, 32'h00000044);
        step();
        step();
        checkVal("wd.timeout_rreq_rise", 32'(memRreq), 32'd1);

        // never ack: abort eight cycles after rreq rises
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            step();
        end
        checkVal("wd.pre_abort", 32'(abortOut), 32'd0);
        step();
        checkVal("wd.abort", 32'(abortOut), 32'd1);
        checkVal("wd.rreq_dropped", 32'(memRreq), 32'd0);
        checkVal("wd.fetch_dropped", 32'(fetchPhase), 32'd0);
        memAck = 1'b1; jisr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checkVal("halt.abort_sticky", 32'(abortOut), 32'd1);
            checkVal("halt.rreq", 32'(memRreq), 32'd0);
            checkVal("halt.wreq", 32'(memWreq), 32'd0);
        end
        memAck = 1'b0; jisr = 1'b0;
        rstN = 1'b0;
        #1;
        checkVal("halt.reset_abort", 32'(abortOut), 32'd0);

        // async reset while a request is raised
        @(posedge clk);
        #1;
        rstN = 1'b1;
        step();
        checkVal("areset.rreq_up", 32'(memRreq), 32'd1);
        rstN = 1'b0;
        #1;
        checkVal("areset.rreq_drop", 32'(memRreq), 32'd0);
        checkVal("areset.fetch_drop", 32'(fetchPhase), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
